sg_stream_filter: RTL and testbench
===================================

Name: sg_stream_filter

Overview:
- Synthesizable, streaming Savitzky-Golay smoothing filter for framed integer sample streams, with quadratic/cubic fit and fixed integer coefficients.
- Replaces gradient-descent fitting with exact precomputed coefficients: one output per input sample, valid/ready handshake on both sides.
- Frame edges are padded by replicating the first and last full-window results; frames shorter than the window pass through raw.
- Sits between the sample-ingest stream and downstream analysis/logging.

Parameters:
- DATA_W, 16: signed width of in_data and out_data.
- WINDOW, 7: odd window length. Only 5, 7 or 9 are legal; any other value is an elaboration error. HALF = WINDOW/2.
- CNT_W, 16: width of the per-frame sample counter. Frames longer than 2^CNT_W-1 samples are still legal, because the counter saturates.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous frame abort: return to FILL and drop the partial frame; out_valid=0 next cycle.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept the sample.
- in_data  in  DATA_W  signed input sample.
- in_last  in  1  final sample of frame (qualified by in_valid&&in_ready).
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  signed filtered sample.
- out_last  out  1  final output of frame.
- out_sat  out  1  out_data was saturated (per-sample, travels with out_data).

Behaviour:
- Coefficients (the NORM value is the divisor):
  - W5: -3,12,17,12,-3 with NORM=35.
  - W7: -2,3,6,7,6,3,-2 with NORM=21.
  - W9: -21,14,39,54,59,54,39,14,-21 with NORM=231.
- Arithmetic:
  - acc = sum over the window of c_k*x_k, in DATA_W+10 signed bits; it cannot overflow.
  - y = acc/NORM, rounded to nearest, ties away from zero.
  - y is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_sat=1 when clipped.
- Window: a shift register of WINDOW samples; the oldest sample is at index 0.
- Output register: a single register holds out_data/out_last/out_sat.
  - Once out_valid=1, its contents stay stable until out_ready=1.
  - Latency: out_valid rises in the cycle after the accepting handshake of the sample that completes a window.
- Reset (rst_n=0): out_valid=0, out_data=0, out_last=0, out_sat=0, in_ready=0, window cleared, count=0, state=FILL. in_ready rises in the first cycle after reset release.
- FSM states: FILL, PREFIX, RUN, TAIL, RAW.
  - FILL: in_ready=1 while the output register is empty or being drained.
    - Each accepted sample shifts in and increments count.
    - When the WINDOW-th sample is accepted without in_last: load y0 and go to PREFIX.
    - WINDOW-th sample with in_last: load y0 and go to TAIL.
    - in_last with count+1<WINDOW: go to RAW.
  - PREFIX: in_ready=0. y0 is re-presented so that it is emitted HALF+1 times in total, then go to RUN.
  - RUN: in_ready = !out_valid || out_ready. Each accepted sample yields one output.
    - in_last accepted: go to TAIL.
  - TAIL: in_ready=0. The last computed y is emitted HALF additional times. out_last=1 on the final repeat, then go to FILL with count=0.
  - RAW: in_ready=0. The N buffered samples are emitted unmodified, oldest first, with out_sat=0 and out_last on the Nth, then go to FILL.
- Output count always equals input count N per frame: HALF + (N-WINDOW+1) + HALF for N≥WINDOW, or N for N<WINDOW.
- Simultaneous events:
  - In RUN, a downstream pop and an upstream accept in the same cycle both complete, with no bubble.
  - clear overrides all handshakes in that cycle.
- rst_n assertion mid-frame discards everything asynchronously; no partial output is emitted after release.

Test Plan:
- W7, DATA_W=16, frame of 10 samples all =100 -> 10 outputs all 100, out_last only on the 10th, out_sat=0.
- W7, ramp 0..9 -> outputs 3,3,3,3,4,5,6,6,6,6. Quadratic/cubic exactness holds.
- W7, frame 3 samples 5,-7,9 (in_last on the 3rd) -> raw 5,-7,9 with out_last on 9. A single-sample frame outputs itself with out_last.
- W7, window -32768,32767,32767,32767,32767,32767,-32768 -> acc=950247, y=32767, out_sat=1. Rounding check: acc=31 with NORM=21 gives 1, acc=-32 gives -2.
- Random out_ready (50% duty) over 3 back-to-back frames of 20 -> output matches the golden model sample for sample, no drops or duplicates, data stable while stalled.
- rst_n low mid-RUN, then a new frame of 8 -> out_valid=0 during reset. The new frame is a correct 8 outputs with no remnants. A clear pulse mid-frame behaves the same synchronously.

Source files
------------

// File: rtl/sg_stream_if.sv
// Valid/ready sample stream carrying a frame marker and a per-sample saturation flag.
interface sg_stream_if #(
   parameter int DATA_W = 16
) ();
   logic                     valid;
   logic                     ready;
   logic signed [DATA_W-1:0] data;
   logic                     last;
   logic                     sat;

   modport master (output valid, data, last, sat, input ready);
   modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/sg_stream_filter.sv
// Streaming Savitzky-Golay smoother: one output per input sample, edges padded by
// replicating the first/last full-window result, short frames passed through raw.
module sg_stream_filter #(
   parameter int DATA_W = 16,
   parameter int WINDOW = 7,
   parameter int CNT_W  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   sg_stream_if.slave  sink,
   sg_stream_if.master source
);

   localparam int HALF   = WINDOW / 2;
   localparam int COEF_W = 8;
   localparam int ACC_W  = DATA_W + 10;
   localparam int NORM   = (WINDOW == 5) ? 35 : (WINDOW == 7) ? 21 : 231;
   localparam int REP_W  = 4;
   localparam int IDX_W  = $clog2(WINDOW);

   localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   generate
      if (WINDOW != 5 && WINDOW != 7 && WINDOW != 9) begin : g_bad_window
         $error("sg_stream_filter: WINDOW must be 5, 7 or 9");
      end
   endgenerate

   // Coefficients are symmetric, so they are looked up by distance from the centre tap.
   function automatic logic signed [COEF_W-1:0] coef(input int k);
      int d;
      int c;
      d = (k > HALF) ? k - HALF : HALF - k;
      case (WINDOW)
         5:       c = (d == 0) ? 17 : (d == 1) ? 12 : -3;
         7:       c = (d == 0) ? 7 : (d == 1) ? 6 : (d == 2) ? 3 : -2;
         default: c = (d == 0) ? 59 : (d == 1) ? 54 : (d == 2) ? 39 : (d == 3) ? 14 : -21;
      endcase
      return COEF_W'(c);
   endfunction

   // NORM is odd, so adding floor(NORM/2) to the magnitude gives round-half-away.
   function automatic logic signed [ACC_W-1:0] round_div(input logic signed [ACC_W-1:0] a);
      logic [ACC_W-1:0] mag;
      logic [ACC_W-1:0] q;
      mag = a[ACC_W-1] ? $unsigned(-a) : $unsigned(a);
      q   = (mag + ACC_W'(NORM / 2)) / ACC_W'(NORM);
      return a[ACC_W-1] ? -$signed(q) : $signed(q);
   endfunction

   function automatic logic signed [DATA_W-1:0] clip(input logic signed [ACC_W-1:0] y);
      logic signed [ACC_W-1:0] c;
      c = (y > Y_MAX) ? Y_MAX : (y < Y_MIN) ? Y_MIN : y;
      return DATA_W'(c);
   endfunction

   function automatic logic is_sat(input logic signed [ACC_W-1:0] y);
      return (y > Y_MAX) || (y < Y_MIN);
   endfunction

   typedef enum logic [2:0] {FILL, PREFIX, RUN, TAIL, RAW} state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic signed [DATA_W-1:0] win_p0 [WINDOW];
   logic signed [DATA_W-1:0] win_nxt [WINDOW];
   logic [CNT_W-1:0]         count;
   logic [REP_W-1:0]         rep;
   logic [REP_W-1:0]         rep_nxt;
   logic                     armed;
   logic signed [ACC_W-1:0]  acc_p0;
   logic signed [ACC_W-1:0]  y_p0;
   logic signed [DATA_W-1:0] hold_data_p1;
   logic                     hold_sat_p1;
   logic signed [DATA_W-1:0] out_data_p1;
   logic                     out_last_p1;
   logic                     out_sat_p1;
   logic                     vld_p1;
   logic                     out_free;
   logic                     accept;
   logic                     win_full;
   logic                     load;
   logic                     take_y;
   logic                     ld_last;
   logic                     ld_sat;
   logic signed [DATA_W-1:0] ld_data;
   logic [IDX_W-1:0]         raw_idx;

   assign out_free    = !vld_p1 || source.ready;
   assign sink.ready  = armed && !clear && out_free && (state == FILL || state == RUN);
   assign accept      = sink.valid && sink.ready;
   assign win_full    = (count == CNT_W'(WINDOW - 1));
   assign raw_idx     = IDX_W'(WINDOW) - IDX_W'(rep);

   assign source.valid = vld_p1;
   assign source.data  = out_data_p1;
   assign source.last  = out_last_p1;
   assign source.sat   = out_sat_p1;

   // Stage p0: window as it will look after the incoming sample shifts in.
   always_comb begin
      for (int k = 0; k < WINDOW - 1; k++) win_nxt[k] = win_p0[k + 1];
      win_nxt[WINDOW-1] = sink.data;
   end

   always_comb begin
      acc_p0 = '0;
      for (int k = 0; k < WINDOW; k++)
         acc_p0 = acc_p0 + ACC_W'(coef(k)) * ACC_W'(win_nxt[k]);
   end

   assign y_p0 = round_div(acc_p0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = FILL;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  if (win_full)       state_nxt = sink.last ? TAIL : PREFIX;
                  else if (sink.last) state_nxt = RAW;
               end
            end
            PREFIX:    if (out_free && rep == REP_W'(1)) state_nxt = RUN;
            RUN:       if (accept && sink.last) state_nxt = TAIL;
            TAIL, RAW: if (out_free && rep == REP_W'(1)) state_nxt = FILL;
            default:   state_nxt = FILL;
         endcase
      end
   end

   // A full window that is also the frame end must still produce 2*HALF padding copies.
   always_comb begin
      load    = 1'b0;
      take_y  = 1'b0;
      ld_data = clip(y_p0);
      ld_sat  = is_sat(y_p0);
      ld_last = 1'b0;
      rep_nxt = rep;
      case (state)
         FILL: begin
            if (accept) begin
               if (win_full) begin
                  load    = 1'b1;
                  take_y  = 1'b1;
                  rep_nxt = sink.last ? REP_W'(2 * HALF) : REP_W'(HALF);
               end else if (sink.last) begin
                  rep_nxt = REP_W'(count) + REP_W'(1);
               end
            end
         end
         PREFIX: begin
            if (out_free) begin
               load    = 1'b1;
               ld_data = hold_data_p1;
               ld_sat  = hold_sat_p1;
               rep_nxt = rep - REP_W'(1);
            end
         end
         RUN: begin
            if (accept) begin
               load   = 1'b1;
               take_y = 1'b1;
               if (sink.last) rep_nxt = REP_W'(HALF);
            end
         end
         TAIL: begin
            if (out_free) begin
               load    = 1'b1;
               ld_data = hold_data_p1;
               ld_sat  = hold_sat_p1;
               ld_last = (rep == REP_W'(1));
               rep_nxt = rep - REP_W'(1);
            end
         end
         RAW: begin
            if (out_free) begin
               load    = 1'b1;
               ld_data = win_p0[raw_idx];
               ld_sat  = 1'b0;
               ld_last = (rep == REP_W'(1));
               rep_nxt = rep - REP_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed <= 1'b0;
         count <= '0;
         rep   <= '0;
      end else begin
         armed <= 1'b1;
         if (clear) begin
            count <= '0;
            rep   <= '0;
         end else begin
            rep <= rep_nxt;
            if (state_nxt == FILL && state != FILL) count <= '0;
            else if (accept && count != '1)       count <= count + CNT_W'(1);
         end
      end
   end

   // Stage p1: output register plus the held result used for edge replication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < WINDOW; k++) win_p0[k] <= '0;
         hold_data_p1 <= '0;
         hold_sat_p1  <= 1'b0;
         out_data_p1  <= '0;
         out_last_p1  <= 1'b0;
         out_sat_p1   <= 1'b0;
         vld_p1       <= 1'b0;
      end else if (clear) begin
         vld_p1 <= 1'b0;
      end else begin
         if (accept)
            for (int k = 0; k < WINDOW; k++) win_p0[k] <= win_nxt[k];
         if (take_y) begin
            hold_data_p1 <= clip(y_p0);
            hold_sat_p1  <= is_sat(y_p0);
         end
         if (load) begin
            out_data_p1 <= ld_data;
            out_last_p1 <= ld_last;
            out_sat_p1  <= ld_sat;
            vld_p1      <= 1'b1;
         end else if (source.ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sg_stream_filter.sv
// Directed bench for sg_stream_filter (W7, 16-bit): edge padding, raw frames,
// saturation, rounding, stalled back-to-back frames, reset and clear recovery.
module tb_sg_stream_filter;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   sg_stream_if #(.DATA_W(DW)) sink_if ();
   sg_stream_if #(.DATA_W(DW)) src_if ();

   sg_stream_filter #(.DATA_W(DW), .WINDOW(7), .CNT_W(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .sink   (sink_if),
      .source (src_if)
   );

   int   tests = 0;
   int   failed = 0;
   int   stim[$];
   int   got_d[$];
   logic got_l[$];
   logic got_s[$];
   int   exp_d[$];
   logic exp_l[$];
   logic exp_s[$];
   bit   rand_rdy = 1'b0;
   bit   stab_on = 1'b0;
   int   stab_err = 0;
   logic prev_stall = 1'b0;
   logic [DW-1:0] prev_d = '0;
   logic prev_l = 1'b0;
   logic prev_s = 1'b0;

   always @(negedge clk) begin
      if (stab_on && prev_stall &&
          (src_if.valid !== 1'b1 || src_if.data !== prev_d || src_if.last !== prev_l || src_if.sat !== prev_s))
         stab_err <= stab_err + 1;
      prev_stall <= src_if.valid && !src_if.ready;
      prev_d     <= src_if.data;
      prev_l     <= src_if.last;
      prev_s     <= src_if.sat;
      if (src_if.valid === 1'b1 && src_if.ready === 1'b1) begin
         got_d.push_back(int'(src_if.data));
         got_l.push_back(src_if.last);
         got_s.push_back(src_if.sat);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) src_if.ready = 1'($urandom_range(0, 1));
   endtask

   task automatic clear_got();
      got_d.delete();
      got_l.delete();
      got_s.delete();
   endtask

   task automatic send_frame(input bit with_last);
      int i = 0;
      int guard = 0;
      while (i < stim.size() && guard < 4000) begin
         sink_if.valid = 1'b1;
         sink_if.data  = DW'(stim[i]);
         sink_if.last  = with_last && (i == stim.size() - 1);
         @(negedge clk);
         if (sink_if.ready === 1'b1) i++;
         tick();
         guard++;
      end
      sink_if.valid = 1'b0;
      sink_if.last  = 1'b0;
      tests++;
      if (i != stim.size()) begin
         failed++;
         $display("FAIL send_frame accepted=%0d required=%0d", i, stim.size());
      end
   endtask

   task automatic drain(input int target);
      int guard = 0;
      while (got_d.size() < target && guard < 4000) begin
         tick();
         guard++;
      end
      repeat (4) tick();
   endtask

   // Reference: full-window result at the clamped centre, round half away from zero.
   task automatic build_expect();
      int n;
      n = stim.size();
      for (int j = 0; j < n; j++) begin
         int c;
         int a;
         int y;
         logic s;
         if (n < 7) begin
            y = stim[j];
            s = 1'b0;
         end else begin
            c = (j < 3) ? 3 : (j > n - 4) ? n - 4 : j;
            a = -2*stim[c-3] + 3*stim[c-2] + 6*stim[c-1] + 7*stim[c] + 6*stim[c+1] + 3*stim[c+2] - 2*stim[c+3];
            y = (a >= 0) ? (2*a + 21) / 42 : (2*a - 21) / 42;
            s = (y > 32767) || (y < -32768);
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
         end
         exp_d.push_back(y);
         exp_l.push_back(j == n - 1);
         exp_s.push_back(s);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (src_if.valid !== 1'b0 || src_if.data !== '0 || src_if.last !== 1'b0 || src_if.sat !== 1'b0) begin
         failed++;
         $display("FAIL reset_out valid=%b data=%0d last=%b sat=%b required 0/0/0/0",
                  src_if.valid, src_if.data, src_if.last, src_if.sat);
      end
      tests++;
      if (sink_if.ready !== 1'b0) begin
         failed++;
         $display("FAIL reset_in_ready got=%b required 0", sink_if.ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (sink_if.ready !== 1'b1) begin
         failed++;
         $display("FAIL release_in_ready got=%b required 1", sink_if.ready);
      end
      tick();
   endtask

   task automatic test_const();
      clear_got();
      stim.delete();
      repeat (10) stim.push_back(100);
      send_frame(1'b1);
      drain(10);
      tests++;
      if (got_d.size() != 10) begin
         failed++;
         $display("FAIL const_count got=%0d required 10", got_d.size());
      end
      for (int k = 0; k < 10 && k < got_d.size(); k++) begin
         tests++;
         if (got_d[k] !== 100 || got_l[k] !== (k == 9) || got_s[k] !== 1'b0) begin
            failed++;
            $display("FAIL const[%0d] got=%0d/%b/%b required 100/%b/0", k, got_d[k], got_l[k], got_s[k], k == 9);
         end
      end
   endtask

   task automatic test_ramp();
      int ed[10] = '{3, 3, 3, 3, 4, 5, 6, 6, 6, 6};
      clear_got();
      stim.delete();
      for (int i = 0; i < 10; i++) stim.push_back(i);
      send_frame(1'b1);
      drain(10);
      tests++;
      if (got_d.size() != 10) begin
         failed++;
         $display("FAIL ramp_count got=%0d required 10", got_d.size());
      end
      for (int k = 0; k < 10 && k < got_d.size(); k++) begin
         tests++;
         if (got_d[k] !== ed[k] || got_l[k] !== (k == 9) || got_s[k] !== 1'b0) begin
            failed++;
            $display("FAIL ramp[%0d] got=%0d/%b/%b required %0d/%b/0", k, got_d[k], got_l[k], got_s[k], ed[k], k == 9);
         end
      end
   endtask

   task automatic test_raw();
      int   ed[4] = '{5, -7, 9, -123};
      logic el[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      clear_got();
      stim = '{5, -7, 9};
      send_frame(1'b1);
      stim = '{-123};
      send_frame(1'b1);
      drain(4);
      tests++;
      if (got_d.size() != 4) begin
         failed++;
         $display("FAIL raw_count got=%0d required 4", got_d.size());
      end
      for (int k = 0; k < 4 && k < got_d.size(); k++) begin
         tests++;
         if (got_d[k] !== ed[k] || got_l[k] !== el[k] || got_s[k] !== 1'b0) begin
            failed++;
            $display("FAIL raw[%0d] got=%0d/%b/%b required %0d/%b/0", k, got_d[k], got_l[k], got_s[k], ed[k], el[k]);
         end
      end
   endtask

   task automatic test_saturation();
      clear_got();
      stim = '{-32768, 32767, 32767, 32767, 32767, 32767, -32768};
      send_frame(1'b1);
      stim = '{32767, -32768, -32768, -32768, -32768, -32768, 32767};
      send_frame(1'b1);
      drain(14);
      tests++;
      if (got_d.size() != 14) begin
         failed++;
         $display("FAIL sat_count got=%0d required 14", got_d.size());
      end
      for (int k = 0; k < 14 && k < got_d.size(); k++) begin
         int e;
         e = (k < 7) ? 32767 : -32768;
         tests++;
         if (got_d[k] !== e || got_l[k] !== (k == 6 || k == 13) || got_s[k] !== 1'b1) begin
            failed++;
            $display("FAIL sat[%0d] got=%0d/%b/%b required %0d/%b/1", k, got_d[k], got_l[k], got_s[k], e, k == 6 || k == 13);
         end
      end
   endtask

   task automatic test_rounding();
      clear_got();
      stim = '{0, 0, 0, 4, 0, 1, 0};
      send_frame(1'b1);
      stim = '{2, 0, 0, -4, 0, 0, 0};
      send_frame(1'b1);
      drain(14);
      tests++;
      if (got_d.size() != 14) begin
         failed++;
         $display("FAIL round_count got=%0d required 14", got_d.size());
      end
      for (int k = 0; k < 14 && k < got_d.size(); k++) begin
         int e;
         e = (k < 7) ? 1 : -2;
         tests++;
         if (got_d[k] !== e || got_l[k] !== (k == 6 || k == 13) || got_s[k] !== 1'b0) begin
            failed++;
            $display("FAIL round[%0d] got=%0d/%b/%b required %0d/%b/0", k, got_d[k], got_l[k], got_s[k], e, k == 6 || k == 13);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_got();
      exp_d.delete();
      exp_l.delete();
      exp_s.delete();
      stab_err = 0;
      stab_on  = 1'b1;
      rand_rdy = 1'b1;
      for (int f = 0; f < 3; f++) begin
         stim.delete();
         for (int i = 0; i < 20; i++) stim.push_back(((i*i*37 + f*911) % 4001) - 2000);
         build_expect();
         send_frame(1'b1);
      end
      drain(60);
      tests++;
      if (got_d.size() != 60) begin
         failed++;
         $display("FAIL b2b_count got=%0d required 60", got_d.size());
      end
      for (int k = 0; k < 60 && k < got_d.size(); k++) begin
         tests++;
         if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k] || got_s[k] !== exp_s[k]) begin
            failed++;
            $display("FAIL b2b[%0d] got=%0d/%b/%b required %0d/%b/%b", k, got_d[k], got_l[k], got_s[k],
                     exp_d[k], exp_l[k], exp_s[k]);
         end
      end
      tests++;
      if (stab_err != 0) begin
         failed++;
         $display("FAIL b2b_stall_stability changes=%0d required 0", stab_err);
      end
      rand_rdy = 1'b0;
      stab_on  = 1'b0;
      src_if.ready = 1'b1;
      tick();
   endtask

   task automatic check_ramp8(input string name);
      int ed[8] = '{13, 13, 13, 13, 14, 14, 14, 14};
      clear_got();
      stim.delete();
      for (int i = 10; i < 18; i++) stim.push_back(i);
      send_frame(1'b1);
      drain(8);
      tests++;
      if (got_d.size() != 8) begin
         failed++;
         $display("FAIL %s_count got=%0d required 8", name, got_d.size());
      end
      for (int k = 0; k < 8 && k < got_d.size(); k++) begin
         tests++;
         if (got_d[k] !== ed[k] || got_l[k] !== (k == 7) || got_s[k] !== 1'b0) begin
            failed++;
            $display("FAIL %s[%0d] got=%0d/%b/%b required %0d/%b/0", name, k, got_d[k], got_l[k], got_s[k], ed[k], k == 7);
         end
      end
   endtask

   task automatic test_reset_midframe();
      stim.delete();
      for (int i = 0; i < 9; i++) stim.push_back(i * 10);
      send_frame(1'b0);
      src_if.ready = 1'b0;
      tick();
      @(negedge clk);
      tests++;
      if (src_if.valid !== 1'b1) begin
         failed++;
         $display("FAIL midrst_stalled valid=%b required 1", src_if.valid);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if (src_if.valid !== 1'b0 || sink_if.ready !== 1'b0) begin
         failed++;
         $display("FAIL midrst_during valid=%b in_ready=%b required 0/0", src_if.valid, sink_if.ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      src_if.ready = 1'b1;
      tick();
      tick();
      check_ramp8("midrst");
   endtask

   task automatic test_clear();
      stim.delete();
      for (int i = 0; i < 9; i++) stim.push_back(500 - i * 7);
      send_frame(1'b0);
      src_if.ready = 1'b0;
      tick();
      clear = 1'b1;
      sink_if.valid = 1'b1;
      sink_if.data  = 16'sd999;
      @(negedge clk);
      tests++;
      if (sink_if.ready !== 1'b0) begin
         failed++;
         $display("FAIL clear_in_ready got=%b required 0", sink_if.ready);
      end
      @(posedge clk);
      #1;
      clear = 1'b0;
      sink_if.valid = 1'b0;
      @(negedge clk);
      tests++;
      if (src_if.valid !== 1'b0) begin
         failed++;
         $display("FAIL clear_out_valid got=%b required 0", src_if.valid);
      end
      src_if.ready = 1'b1;
      tick();
      check_ramp8("clear");
   endtask

   initial begin
      sink_if.valid = 1'b0;
      sink_if.data  = '0;
      sink_if.last  = 1'b0;
      sink_if.sat   = 1'b0;
      src_if.ready  = 1'b1;
      test_reset();
      test_const();
      test_ramp();
      test_raw();
      test_saturation();
      test_rounding();
      test_back_to_back();
      test_reset_midframe();
      test_clear();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
